// File: rtl/spi_pkg.sv
// Shared definitions for the 8-bit SPI master: FSM state encoding, frame
// constants, mode decode and shift-order helpers.
// Build option: SPI_MASTER_MSB_FIRST_EN selects MSB-first shifting
// (default build is LSB-first).
package spi_pkg;

   localparam int SPI_DATA_W = 8;
   localparam int SPI_EDGE_W = 5;
   localparam logic [SPI_EDGE_W-1:0] SPI_EDGE_CNT = 5'd16;

   // FSM state encoding (IDLE, SETUP, XFER, HOLD)
   typedef logic [1:0] spi_state_t;
   localparam spi_state_t ST_IDLE  = 2'd0;
   localparam spi_state_t ST_SETUP = 2'd1;
   localparam spi_state_t ST_XFER  = 2'd2;
   localparam spi_state_t ST_HOLD  = 2'd3;

   function automatic logic mode_cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

   // Bit that leaves the shift register next
   function automatic logic first_bit(input logic [SPI_DATA_W-1:0] d);
`ifdef SPI_MASTER_MSB_FIRST_EN
      return d[SPI_DATA_W-1];
`else
      return d[0];
`endif
   endfunction

   // Drop the bit just sent
   function automatic logic [SPI_DATA_W-1:0] shift_out(input logic [SPI_DATA_W-1:0] d);
`ifdef SPI_MASTER_MSB_FIRST_EN
      return {d[SPI_DATA_W-2:0], 1'b0};
`else
      return {1'b0, d[SPI_DATA_W-1:1]};
`endif
   endfunction

   // Insert a received bit so the first one ends at the first-sent position
   function automatic logic [SPI_DATA_W-1:0] shift_in(input logic [SPI_DATA_W-1:0] d,
                                                      input logic b);
`ifdef SPI_MASTER_MSB_FIRST_EN
      return {d[SPI_DATA_W-2:0], b};
`else
      return {b, d[SPI_DATA_W-1:1]};
`endif
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: divides clk by CLK_DIV per half-period while a frame runs,
// counts the 16 sck toggles and flags leading/trailing/last edges.
// While idle, sck follows the CPOL level presented on cpol.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic cpol,
   output logic half_tick,
   output logic lead_edge,
   output logic trail_edge,
   output logic last_edge,
   output logic sck
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DIV_ONE  = CW'(1);

   logic [CW-1:0]         div_cnt_r;
   logic [SPI_EDGE_W-1:0] edge_cnt_r;
   logic                  sck_r;
   logic                  toggle_s;

   // Strobe decode; an edge count with bit0 clear means the next toggle is odd (leading)
   always_comb begin
      half_tick  = run && (div_cnt_r == DIV_LAST);
      toggle_s   = half_tick && (edge_cnt_r != SPI_EDGE_CNT);
      lead_edge  = toggle_s && !edge_cnt_r[0];
      trail_edge = toggle_s && edge_cnt_r[0];
      last_edge  = toggle_s && (edge_cnt_r == (SPI_EDGE_CNT - 5'd1));
   end

   // Divider, edge counter and sck register; counters park at zero while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r  <= '0;
         edge_cnt_r <= '0;
         sck_r      <= 1'b0;
      end else if (!run) begin
         div_cnt_r  <= '0;
         edge_cnt_r <= '0;
         sck_r      <= cpol;
      end else begin
         if (half_tick) begin
            div_cnt_r <= '0;
         end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
         end
         if (toggle_s) begin
            sck_r      <= ~sck_r;
            edge_cnt_r <= edge_cnt_r + 5'd1;
         end
      end
   end

   assign sck = sck_r;

endmodule

// File: rtl/spi_master.sv
// 8-bit full-duplex SPI master, all four CPOL/CPHA modes, one byte per start.
// Build option: SPI_MASTER_MSB_FIRST_EN switches to MSB-first shifting;
// undefined (default) is LSB-first. Timing is identical in both builds.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SPI_DATA_W-1:0] tx_data,
   input  logic [1:0]            mode,
   output logic                  busy,
   output logic                  done,
   output logic [SPI_DATA_W-1:0] rx_data,
   output logic                  sck,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  sl_se
);

   spi_state_t            state_r;
   logic [1:0]            mode_r;
   logic [SPI_DATA_W-1:0] tx_sr_r;
   logic [SPI_DATA_W-1:0] rx_sr_r;
   logic [SPI_DATA_W-1:0] rx_data_r;
   logic                  mosi_r;
   logic                  sl_se_r;
   logic                  busy_r;
   logic                  done_r;

   logic run_s, cpol_idle_s, cpha_s, shift_s, sample_s;
   logic half_tick_s, lead_s, trail_s, last_s, sck_s;

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run_s),
      .cpol       (cpol_idle_s),
      .half_tick  (half_tick_s),
      .lead_edge  (lead_s),
      .trail_edge (trail_s),
      .last_edge  (last_s),
      .sck        (sck_s)
   );

   // Map sck edges to shift/sample events for the frozen CPHA
   always_comb begin
      run_s       = (state_r != ST_IDLE);
      cpol_idle_s = mode_cpol(mode);
      cpha_s      = mode_cpha(mode_r);
      if (cpha_s) begin
         shift_s  = lead_s;
         sample_s = trail_s;
      end else begin
         shift_s  = trail_s && !last_s;
         sample_s = lead_s;
      end
   end

   // Frame FSM plus tx/rx shift registers; edge events override the FSM defaults
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         mode_r    <= 2'b00;
         tx_sr_r   <= '0;
         rx_sr_r   <= '0;
         rx_data_r <= '0;
         mosi_r    <= 1'b0;
         sl_se_r   <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               mode_r <= mode;
               if (start) begin
                  state_r <= ST_SETUP;
                  busy_r  <= 1'b1;
                  sl_se_r <= 1'b0;
                  rx_sr_r <= '0;
                  if (mode_cpha(mode)) begin
                     mosi_r  <= 1'b0;
                     tx_sr_r <= tx_data;
                  end else begin
                     mosi_r  <= first_bit(tx_data);
                     tx_sr_r <= shift_out(tx_data);
                  end
               end
            end
            ST_SETUP: begin
               if (half_tick_s) begin
                  state_r <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (last_s) begin
                  state_r <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (half_tick_s) begin
                  state_r   <= ST_IDLE;
                  sl_se_r   <= 1'b1;
                  mosi_r    <= 1'b0;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  rx_data_r <= rx_sr_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
         if (shift_s) begin
            mosi_r  <= first_bit(tx_sr_r);
            tx_sr_r <= shift_out(tx_sr_r);
         end
         if (sample_s) begin
            rx_sr_r <= shift_in(rx_sr_r, miso);
         end
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign rx_data = rx_data_r;
   assign sck     = sck_s;
   assign mosi    = mosi_r;
   assign sl_se   = sl_se_r;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: three instances (CLK_DIV = 1, 2, 4),
// a cycle-level reference model derived from the frame timing rules and a
// behavioural SPI slave that reacts to the observed sck edges.
module tb_spi_master;

   logic       clk;
   logic       rst_n;
   logic       start_a   [3];
   logic [7:0] tx_data_a [3];
   logic [1:0] mode_a    [3];
   logic       busy_a    [3];
   logic       done_a    [3];
   logic [7:0] rx_data_a [3];
   logic       sck_a     [3];
   logic       mosi_a    [3];
   logic       miso_a    [3];
   logic       sl_se_a   [3];

   int n_checks = 0;
   int n_errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_master #(.CLK_DIV((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .start   (start_a[g]),
         .tx_data (tx_data_a[g]),
         .mode    (mode_a[g]),
         .busy    (busy_a[g]),
         .done    (done_a[g]),
         .rx_data (rx_data_a[g]),
         .sck     (sck_a[g]),
         .mosi    (mosi_a[g]),
         .miso    (miso_a[g]),
         .sl_se   (sl_se_a[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int div_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 4;
   endfunction

   // Wire position of the i-th bit on the line
   function automatic int bpos(input int i);
`ifdef SPI_MASTER_MSB_FIRST_EN
      return 7 - i;
`else
      return i;
`endif
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One frame on instance k. skip_start: frame was already requested by the
   // previous call; hold_start: keep start high and chain nxt_tx at done;
   // pulse_cyc: stray start pulse; rst_cyc: assert reset at that cycle.
   task automatic run_frame(input int k, input logic [7:0] tx, input logic [1:0] md,
                            input logic [7:0] sb, input bit skip_start, input bit hold_start,
                            input logic [7:0] nxt_tx, input int pulse_cyc, input int rst_cyc);
      int   d;
      int   t;
      int   idx;
      int   sidx;
      int   edges;
      logic prev;
      logic cpol;
      logic cpha;
      logic e_mosi;
      d     = div_of(k);
      cpol  = md[1];
      cpha  = md[0];
      edges = 0;
      prev  = cpol;
      if (!skip_start) begin
         mode_a[k]    = md;
         tx_data_a[k] = tx;
         start_a[k]   = 1'b0;
         @(negedge clk);
         check_eq($sformatf("idle_sck k%0d", k), 32'(sck_a[k]), 32'(cpol));
         check_eq($sformatf("idle_sl_se k%0d", k), 32'(sl_se_a[k]), 32'd1);
         start_a[k] = 1'b1;
      end
      for (int c = 1; c <= 2 + 17 * d; c++) begin
         @(negedge clk);
         if (c == 1 && !hold_start) start_a[k] = 1'b0;
         if (c == 2) begin
            tx_data_a[k] = 8'($urandom);
            mode_a[k]    = 2'($urandom);
         end
         if (c == pulse_cyc) start_a[k] = 1'b1;
         if (c == pulse_cyc + 1) start_a[k] = 1'b0;
         if (c == rst_cyc) begin
            rst_n      = 1'b0;
            start_a[k] = 1'b0;
            #1;
            check_eq("rst_sl_se", 32'(sl_se_a[k]), 32'd1);
            check_eq("rst_sck", 32'(sck_a[k]), 32'd0);
            check_eq("rst_busy", 32'(busy_a[k]), 32'd0);
            check_eq("rst_mosi", 32'(mosi_a[k]), 32'd0);
            check_eq("rst_done", 32'(done_a[k]), 32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            for (int j = 0; j < 17 * d + 4; j++) begin
               @(negedge clk);
               check_eq("rst_no_done", 32'(done_a[k]), 32'd0);
               check_eq("rst_rx_zero", 32'(rx_data_a[k]), 32'd0);
            end
            return;
         end
         if (c <= 17 * d) begin
            if (sck_a[k] !== prev) edges++;
            prev = sck_a[k];
            t = (c - 1) / d;
            if (t > 16) t = 16;
            check_eq($sformatf("sl_se k%0d c%0d", k, c), 32'(sl_se_a[k]), 32'd0);
            check_eq($sformatf("busy k%0d c%0d", k, c), 32'(busy_a[k]), 32'd1);
            check_eq($sformatf("done k%0d c%0d", k, c), 32'(done_a[k]), 32'd0);
            check_eq($sformatf("sck k%0d c%0d", k, c), 32'(sck_a[k]), 32'(cpol ^ (t % 2 == 1)));
            if (cpha) idx = (t == 0) ? -1 : (t - 1) / 2;
            else      idx = t / 2;
            if (idx > 7) idx = 7;
            e_mosi = (idx < 0) ? 1'b0 : tx[bpos(idx)];
            check_eq($sformatf("mosi k%0d c%0d", k, c), 32'(mosi_a[k]), 32'(e_mosi));
            if (cpha) sidx = (edges == 0) ? 0 : (edges - 1) / 2;
            else      sidx = edges / 2;
            if (sidx > 7) sidx = 7;
            miso_a[k] = sb[bpos(sidx)];
         end else if (c == 1 + 17 * d) begin
            check_eq($sformatf("done_pulse k%0d", k), 32'(done_a[k]), 32'd1);
            check_eq($sformatf("end_sl_se k%0d", k), 32'(sl_se_a[k]), 32'd1);
            check_eq($sformatf("end_busy k%0d", k), 32'(busy_a[k]), 32'd0);
            check_eq($sformatf("end_mosi k%0d", k), 32'(mosi_a[k]), 32'd0);
            check_eq($sformatf("rx_data k%0d", k), 32'(rx_data_a[k]), 32'(sb));
            check_eq($sformatf("sck_toggles k%0d", k), 32'(edges), 32'd16);
            if (hold_start) begin
               tx_data_a[k] = nxt_tx;
               mode_a[k]    = md;
               return;
            end
         end else begin
            check_eq($sformatf("done_width k%0d", k), 32'(done_a[k]), 32'd0);
            check_eq($sformatf("rx_hold k%0d", k), 32'(rx_data_a[k]), 32'(sb));
            check_eq($sformatf("post_busy k%0d", k), 32'(busy_a[k]), 32'd0);
         end
      end
   endtask

   initial begin
      logic [7:0] r_tx;
      logic [7:0] r_sb;
      logic [1:0] r_md;
      int         r_k;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_a[k]   = 1'b0;
         tx_data_a[k] = 8'h00;
         mode_a[k]    = 2'd0;
         miso_a[k]    = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("reset_sl_se k%0d", k), 32'(sl_se_a[k]), 32'd1);
         check_eq($sformatf("reset_sck k%0d", k), 32'(sck_a[k]), 32'd0);
         check_eq($sformatf("reset_mosi k%0d", k), 32'(mosi_a[k]), 32'd0);
         check_eq($sformatf("reset_busy k%0d", k), 32'(busy_a[k]), 32'd0);
         check_eq($sformatf("reset_done k%0d", k), 32'(done_a[k]), 32'd0);
         check_eq($sformatf("reset_rx k%0d", k), 32'(rx_data_a[k]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Mode 0, CLK_DIV=2
      run_frame(1, 8'hA5, 2'd0, 8'h3C, 1'b0, 1'b0, 8'h00, -1, -1);
      // Modes 1..3, CLK_DIV=4
      for (int m = 1; m < 4; m++) begin
         run_frame(2, 8'h81, 2'(m), 8'hAA, 1'b0, 1'b0, 8'h00, -1, -1);
      end
      // Back-to-back frames with start held, CLK_DIV=1
      run_frame(0, 8'h01, 2'd0, 8'h5A, 1'b0, 1'b1, 8'hFE, -1, -1);
      run_frame(0, 8'hFE, 2'd0, 8'hC3, 1'b1, 1'b0, 8'h00, -1, -1);
      // Stray start mid-frame
      r_tx = 8'($urandom);
      r_sb = 8'($urandom);
      run_frame(1, r_tx, 2'd1, r_sb, 1'b0, 1'b0, 8'h00, 10, -1);
      // Randomized frames
      for (int i = 0; i < 8; i++) begin
         r_k  = int'($urandom_range(0, 2));
         r_tx = 8'($urandom);
         r_sb = 8'($urandom);
         r_md = 2'($urandom);
         run_frame(r_k, r_tx, r_md, r_sb, 1'b0, 1'b0, 8'h00, -1, -1);
      end
      // Reset mid-frame, mode 0, CLK_DIV=2
      run_frame(1, 8'hA5, 2'd0, 8'h3C, 1'b0, 1'b0, 8'h00, -1, 20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

- Initiator end of the team's 8-bit SPI link; it drives `sck`, `mosi` and the active-low select `sl_se` toward an `SPI_slave` and captures `miso`.
- Accepts one byte per `start` request from a local controller, runs a full-duplex transfer in any of the four CPOL/CPHA modes, and returns the received byte with a one-cycle `done` pulse.
- `sck` is derived from the system clock by a programmable divider.

## Interface

Parameters:
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period; legal range ≥1.

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: transfer request; sampled only while not busy.
- `tx_data` input 8: byte to send; latched when `start` is accepted.
- `mode` input 2: SPI mode; CPOL = `mode[1]`, CPHA = `mode[0]`; registered every cycle while idle, frozen while busy.
- `busy` output 1: high from the cycle after acceptance until the frame ends.
- `done` output 1: one-cycle pulse at frame end.
- `rx_data` output 8: received byte; updated only at `done`, held otherwise.
- `sck` output 1: serial clock.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.
- `sl_se` output 1: slave select, active-low.

## Operation

- Bit order is LSB-first: `tx_data[0]` is sent first, and the first received bit lands in `rx_data[0]`.
- Reset values: `sl_se`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=8'h00, registered mode=0, state IDLE.
- **IDLE**:
  - `sck` = CPOL of the registered mode.
  - `start`=1 latches `tx_data` and freezes the mode, then goes to SETUP.
- **SETUP**:
  - `sl_se`=0, `busy`=1, `sck` at its idle level, for CLK_DIV cycles.
  - If CPHA=0, `mosi` = bit0 from the first SETUP cycle.
  - If CPHA=1, `mosi`=0.
- **XFER**: 16 `sck` toggles, one every CLK_DIV cycles. Odd toggles are leading edges; even toggles are trailing edges.
  - CPHA=0: sample `miso` on each leading edge; shift the next `mosi` bit on trailing edges 2,4,…,14 (no shift after edge 16).
  - CPHA=1: drive bit n on leading edge 2n+1; sample `miso` on each trailing edge.
  - "On edge" means the `clk` rising edge at which the `sck` register toggles. `miso` is sampled at that same `clk` edge.
- **HOLD**: `sck` idle, `sl_se` still 0, for CLK_DIV cycles. Then go to IDLE with `sl_se`=1, `mosi`=0, `busy`=0, `done`=1 and `rx_data` loaded, all in the same cycle.
- `start` while busy is ignored; there is no queueing and no abort.
- `start` in the `done` cycle is accepted, giving back-to-back frames with `sl_se` high for exactly 1 cycle.
- Changing `tx_data` or `mode` mid-frame has no effect.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously), no `done` pulse, and the partial `rx_data` is discarded.
- The internal divider counter is ⌈log2 CLK_DIV⌉ bits, minimum 1, and wraps to 0 at CLK_DIV−1. The edge counter is 5 bits, terminal count 16.

## Timing

- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: `sl_se` falls, `busy` rises.
- `sck` toggle k (k=1..16) is first visible at cycle 1+k·CLK_DIV.
- Cycle 1+17·CLK_DIV: `sl_se` rises, `done`=1, `rx_data` valid. Total frame length is 17·CLK_DIV cycles of `sl_se` low.
- Request-to-`done` latency is 1+17·CLK_DIV cycles (69 at the default).
- CLK_DIV=1: `sck` toggles every cycle and the same rules apply.

## Configuration

- Macro `SPI_MASTER_MSB_FIRST_EN`.
  - Defined: shift order is MSB-first. `tx_data[7]` goes out first and the first received bit lands in `rx_data[7]`.
  - Undefined (default): LSB-first, as described above. This matches `SPI_slave`.
- Timing and handshake are identical in both builds.

## Structure

- Shared package `spi_pkg`:
  - state enum (IDLE, SETUP, XFER, HOLD);
  - `SPI_DATA_W`=8 and edge-count constant 16;
  - mode-decode functions returning CPOL and CPHA.
- One sub-module, `spi_clk_gen`. It holds the divider counter and edge counter and emits `half_tick`, `lead_edge`, `trail_edge` and `last_edge` strobes, plus the registered `sck`. The FSM and shift registers stay in `spi_master`.

## Test plan

- Mode 0, CLK_DIV=2, `tx_data`=8'hA5, slave model returns 8'h3C:
  - `mosi` sequence on leading edges is 1,0,1,0,0,1,0,1;
  - `rx_data`=8'h3C;
  - `done` at cycle 35, `sl_se` low for cycles 1–34.
- Modes 1, 2 and 3 each, CLK_DIV=4, `tx_data`=8'h81, slave returns 8'hAA:
  - `sck` idles at CPOL and makes 16 toggles;
  - `rx_data`=8'hAA;
  - `mosi` changes only on the edge required by CPHA.
- `start` held high continuously, CLK_DIV=1, bytes 8'h01 then 8'hFE: two frames, `sl_se` high exactly 1 cycle between them, each `done` 1 cycle wide.
- `start` pulsed at mid-frame cycle 10: ignored, frame length unchanged, single `done`.
- `rst_n` low at cycle 20 of a mode-0 frame: `sl_se`=1, `sck`=0, `busy`=0 immediately; no `done`; `rx_data` stays 8'h00.
- With `SPI_MASTER_MSB_FIRST_EN` defined, `tx_data`=8'hA5: `mosi` order is 1,0,1,0,0,1,0,1 read from bit7 down; slave byte 8'h3C is received as `rx_data`=8'h3C when the model shifts MSB-first.
